// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//   Buffered UART transmitter. Bytes go into a FIFO_DEPTH-entry FIFO and are
//   sent on tx with a frame format chosen at runtime: 5-8 data bits,
//   none/even/odd parity, and 1 or 2 stop bits. The format is sampled when a
//   byte is popped. Frames can follow each other with no idle bit between
//   them. Every change on tx happens on a baud_tick.
//
// Optional feature (macro UART_TX_CTS_EN):
//   Adds the cts_n input (active-low clear-to-send, already synchronised).
//   A new frame is started only while cts_n is low. A frame that has already
//   started always runs to the end. When the macro is not defined, the block
//   acts as if cts_n were tied low.
//
// Ports:
//   clk, rstn        system clock, async active-low reset
//   baud_tick        one-cycle pulse per bit period
//   cfg_data_bits    00=5, 01=6, 10=7, 11=8 data bits
//   cfg_parity       00/11=none, 01=even, 10=odd
//   cfg_stop2        1 = two stop bits
//   tx_data/valid    enqueue request (dropped while full)
//   tx_ready         FIFO not full
//   tx               serial line, idle high
//   busy             frame in progress
//   fifo_count       FIFO occupancy
//   cts_n            (UART_TX_CTS_EN only) clear-to-send, active low
// ---------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int  FIFO_DEPTH = 16,
    localparam int FIFO_BITS  = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 baud_tick,
`ifdef UART_TX_CTS_EN
    input  logic                 cts_n,
`endif
    input  logic [1:0]           cfg_data_bits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [FIFO_BITS:0]   fifo_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ---------------- FIFO ----------------
    // The pointers carry one extra wrap bit, so full and empty can be told
    // apart without a separate counter.
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [FIFO_BITS:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_BITS:0]   rd_ptr_q, rd_ptr_d;
    logic                 empty, full, push, pop;
    logic [7:0]           head;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                   (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
    assign push  = tx_valid && !full;
    assign head  = mem_q[rd_ptr_q[FIFO_BITS-1:0]];

    assign tx_ready   = !full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{FIFO_BITS{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{FIFO_BITS{1'b0}}, pop};
    end

    // The storage has no reset. A reset only clears the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= tx_data;
        end
    end

    // ---------------- clear-to-send ----------------
    logic cts_ok;
`ifdef UART_TX_CTS_EN
    assign cts_ok = !cts_n;
`else
    assign cts_ok = 1'b1;
`endif

    // ---------------- framer ----------------
    state_e      state_q, state_d;
    logic        tx_q, tx_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    // Frame format captured when the byte is popped.
    logic [1:0]  dbits_q, dbits_d;
    logic        par_en_q, par_en_d;
    logic        par_odd_q, par_odd_d;
    logic        stop2_q, stop2_d;

    logic [3:0]  nbits;
    logic [7:0]  data_mask;
    logic        parity_bit;
    logic        can_pop;

    assign nbits   = 4'd5 + {2'b00, dbits_q};
    assign can_pop = !empty && cts_ok;

    always_comb begin
        data_mask = 8'hFF;
        case (dbits_q)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    end

    // The mask keeps bits above the data width out of the parity.
    assign parity_bit = (^(shift_q & data_mask)) ^ par_odd_q;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        dbits_d    = dbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        pop        = 1'b0;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (can_pop) begin
                        pop = 1'b1;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                S_START: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = 4'd1;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_q < nbits) begin
                        tx_d      = shift_q[bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (par_en_q) begin
                        tx_d    = parity_bit;
                        state_d = S_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
                S_PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    if (stop2_q && !stop_cnt_q) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b1;
                    end else if (can_pop) begin
                        // The next frame starts right after the last stop
                        // bit, with no idle bit between.
                        pop = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase

            if (pop) begin
                shift_d   = head;
                dbits_d   = cfg_data_bits;
                par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                par_odd_d = (cfg_parity == 2'b10);
                stop2_d   = cfg_stop2;
                tx_d      = 1'b0;
                state_d   = S_START;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            dbits_q    <= 2'b11;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            dbits_q    <= dbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
//   Directed bench for uart_tx_framer with FIFO_DEPTH=4. Each expected line
//   bit is either a literal worked out by hand or built by a small frame
//   model (start, data LSB first, parity, stop bits).
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       baud_tick = 1'b0;
    logic [1:0] cfg_data_bits = 2'b11;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, busy;
    logic [2:0] fifo_count;
`ifdef UART_TX_CTS_EN
    logic       cts_n = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int gap = 16;

    logic [255:0] exp_bits;
    int           exp_len;

    always #5 clk = ~clk;

    uart_tx_framer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .baud_tick     (baud_tick),
`ifdef UART_TX_CTS_EN
        .cts_n         (cts_n),
`endif
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx            (tx),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One baud pulse on the next edge. Afterwards the bench sits at edge+1.
    task automatic tick();
        baud_tick = 1'b1;
        @(posedge clk); #1;
        baud_tick = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic enqueue(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic s2);
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = s2;
    endtask

    // Frame model: par 0=none, 1=even, 2=odd.
    task automatic add_frame(input logic [7:0] b, input int nb, input int par, input logic s2);
        logic p;
        p = (par == 2);
        exp_bits[exp_len] = 1'b0;
        exp_len++;
        for (int i = 0; i < nb; i++) begin
            exp_bits[exp_len] = b[i];
            exp_len++;
            p = p ^ b[i];
        end
        if (par != 0) begin
            exp_bits[exp_len] = p;
            exp_len++;
        end
        exp_bits[exp_len] = 1'b1;
        exp_len++;
        if (s2) begin
            exp_bits[exp_len] = 1'b1;
            exp_len++;
        end
    endtask

    task automatic run_bits(input string tag, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            tick();
            chk($sformatf("%s tx bit%0d", tag, i), tx, exp_bits[i]);
            chk($sformatf("%s busy bit%0d", tag, i), busy, 1'b1);
        end
    endtask

    task automatic expect_idle(input string tag);
        tick();
        chk({tag, " idle tx"}, tx, 1'b1);
        chk({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        exp_bits = '0;
        exp_len  = 0;

        // ---- reset state (no clock edge needed)
        #2 rstn = 1'b0;
        #10;
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset count", fifo_count, 3'd0);
        chk("reset ready", tx_ready, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // ---- 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        set_cfg(2'b11, 2'b00, 1'b0);
        enqueue(8'hA5);
        chk("a5 count", fifo_count, 3'd1);
        exp_bits = 256'h34A; exp_len = 10;
        run_bits("8N1", 0, exp_len);
        expect_idle("8N1");
        expect_idle("8N1 again");

        // ---- 7E2 0x83: 0,1,1,0,0,0,0,0, parity 0, 1,1. Config changes mid-frame are ignored.
        set_cfg(2'b10, 2'b01, 1'b1);
        enqueue(8'h83);
        exp_bits = 256'h606; exp_len = 11;
        run_bits("7E2", 0, 1);
        set_cfg(2'b11, 2'b00, 1'b0);
        run_bits("7E2", 1, exp_len);
        expect_idle("7E2");

        // ---- 5O1 0x1F: 0,1,1,1,1,1, parity 0, 1
        set_cfg(2'b00, 2'b10, 1'b0);
        enqueue(8'h1F);
        exp_bits = 256'hBE; exp_len = 8;
        run_bits("5O1", 0, exp_len);
        expect_idle("5O1");

        // ---- a byte written on a tick edge waits for the next tick
        set_cfg(2'b11, 2'b00, 1'b0);
        tx_data = 8'h3C; tx_valid = 1'b1; baud_tick = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0; baud_tick = 1'b0;
        chk("collide tx", tx, 1'b1);
        chk("collide busy", busy, 1'b0);
        chk("collide count", fifo_count, 3'd1);
        repeat (gap - 1) begin @(posedge clk); #1; end
        exp_bits = '0; exp_len = 0;
        add_frame(8'h3C, 8, 0, 1'b0);
        run_bits("collide", 0, exp_len);
        expect_idle("collide");

        // ---- back-to-back frames
        enqueue(8'h55);
        enqueue(8'h0F);
        chk("b2b count", fifo_count, 3'd2);
        exp_bits = '0; exp_len = 0;
        add_frame(8'h55, 8, 0, 1'b0);
        add_frame(8'h0F, 8, 0, 1'b0);
        chk("b2b len", exp_len, 20);
        run_bits("b2b", 0, exp_len);
        expect_idle("b2b");

        // ---- fill past full, then drain
        tx_valid = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            tx_data = 8'(v);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        chk("full count", fifo_count, 3'd4);
        chk("full ready", tx_ready, 1'b0);
        exp_bits = '0; exp_len = 0;
        for (int v = 1; v <= 4; v++) add_frame(8'(v), 8, 0, 1'b0);
        run_bits("drain", 0, exp_len);
        expect_idle("drain");
        chk("drain count", fifo_count, 3'd0);
        chk("drain ready", tx_ready, 1'b1);

        // ---- refill across the pointer wrap, ticks on consecutive cycles
        for (int v = 7; v <= 10; v++) enqueue(8'(v));
        chk("wrap count", fifo_count, 3'd4);
        chk("wrap ready", tx_ready, 1'b0);
        gap = 1;
        exp_bits = '0; exp_len = 0;
        for (int v = 7; v <= 10; v++) add_frame(8'(v), 8, 0, 1'b0);
        run_bits("wrap", 0, exp_len);
        expect_idle("wrap");
        gap = 16;
        chk("wrap empty", fifo_count, 3'd0);

        // ---- reset during data bit 3 with 2 bytes still queued
        enqueue(8'h00);
        enqueue(8'h11);
        enqueue(8'h22);
        repeat (5) tick();
        chk("midrst pre tx", tx, 1'b0);
        chk("midrst pre count", fifo_count, 3'd2);
        #2 rstn = 1'b0;
        #1;
        chk("midrst tx", tx, 1'b1);
        chk("midrst count", fifo_count, 3'd0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst ready", tx_ready, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("post-rst tx %0d", i), tx, 1'b1);
            chk($sformatf("post-rst busy %0d", i), busy, 1'b0);
        end

`ifdef UART_TX_CTS_EN
        // ---- flow control
        cts_n = 1'b1;
        enqueue(8'h81);
        enqueue(8'h42);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("cts hold tx %0d", i), tx, 1'b1);
            chk($sformatf("cts hold busy %0d", i), busy, 1'b0);
        end
        chk("cts hold count", fifo_count, 3'd2);
        cts_n = 1'b0;
        exp_bits = '0; exp_len = 0;
        add_frame(8'h81, 8, 0, 1'b0);
        run_bits("cts f1", 0, 4);
        cts_n = 1'b1;
        run_bits("cts f1", 4, exp_len);
        expect_idle("cts f1");
        chk("cts held count", fifo_count, 3'd1);
        expect_idle("cts still held");
        cts_n = 1'b0;
        exp_bits = '0; exp_len = 0;
        add_frame(8'h42, 8, 0, 1'b0);
        run_bits("cts f2", 0, exp_len);
        expect_idle("cts f2");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
